alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 91 +++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequencer around an external combinational ALU. It holds an 8-entry
// register file, issues one command at a time and returns the result through a
// ready/valid response port.
module alu_seq #(
   parameter int unsigned NREG = 8,
   parameter int unsigned DW   = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_ld,
   input  logic [2:0]    cmd_op,
   input  logic [2:0]    cmd_rd,
   input  logic [2:0]    cmd_rs1,
   input  logic [2:0]    cmd_rs2,
   input  logic [DW-1:0] cmd_imm,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_f,
   input  logic [DW-1:0] alu_out,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic [2:0]    rsp_rd
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

   state_t        state;
   logic [DW-1:0] regs [NREG];
   logic          ld_lat;
   logic [2:0]    rd_lat;
   logic [DW-1:0] imm_lat;
   logic [DW-1:0] wb_data;

   // Loads write the latched immediate; the ALU result is ignored for them.
   assign wb_data = ld_lat ? imm_lat : alu_out;

   // Accept only in idle, and never while reset is held.
   assign cmd_ready = (state == StIdle) && !reset;

   // Single-state-register FSM; all outputs except cmd_ready are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         ld_lat    <= 1'b0;
         rd_lat    <= '0;
         imm_lat   <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_f     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_rd    <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  // Operands read here, so rd == rs sees the pre-write value.
                  ld_lat  <= cmd_ld;
                  rd_lat  <= cmd_rd;
                  imm_lat <= cmd_imm;
                  alu_a   <= regs[cmd_rs1];
                  alu_b   <= regs[cmd_rs2];
                  alu_f   <= cmd_op;
                  state   <= StIssue;
               end
            end
            StIssue: begin
               regs[rd_lat] <= wb_data;
               rsp_data     <= wb_data;
               rsp_rd       <= rd_lat;
               rsp_valid    <= 1'b1;
               state        <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven checks for alu_seq with a behavioural ALU.
module tb_alu_seq;

   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_ld;
   logic [2:0]    cmd_op;
   logic [2:0]    cmd_rd;
   logic [2:0]    cmd_rs1;
   logic [2:0]    cmd_rs2;
   logic [DW-1:0] cmd_imm;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_f;
   logic [DW-1:0] alu_out;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [2:0]    rsp_rd;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit        ld;
      bit [2:0]  op;
      bit [2:0]  rd;
      bit [2:0]  rs1;
      bit [2:0]  rs2;
      bit [31:0] imm;
      bit [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.NREG(8), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ld    (cmd_ld),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rs1   (cmd_rs1),
      .cmd_rs2   (cmd_rs2),
      .cmd_imm   (cmd_imm),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_rd    (rsp_rd)
   );

   always #5 clk = ~clk;

   // External combinational ALU.
   always_comb begin
      alu_out = '0;
      case (alu_f)
         3'b000: alu_out = ~alu_a;
         3'b001: alu_out = alu_a & alu_b;
         3'b010: alu_out = alu_a ^ alu_b;
         3'b011: alu_out = alu_a | alu_b;
         3'b100: alu_out = alu_a - 1;
         3'b101: alu_out = alu_a + alu_b;
         3'b110: alu_out = alu_a - alu_b;
         default: alu_out = alu_a + 1;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full command round trip; entered and left at posedge+1 in idle.
   task automatic run_cmd(input vec_t v, input string name);
      check({name, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
      cmd_ld    = v.ld;
      cmd_op    = v.op;
      cmd_rd    = v.rd;
      cmd_rs1   = v.rs1;
      cmd_rs2   = v.rs2;
      cmd_imm   = v.imm;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({name, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
      check({name, " alu_f"}, 32'(alu_f), 32'(v.op));
      @(posedge clk); #1;
      check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, " rsp_data"}, rsp_data, v.exp);
      check({name, " rsp_rd"}, 32'(rsp_rd), 32'(v.rd));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({name, " rsp_valid clear"}, 32'(rsp_valid), 32'd0);
   endtask

   function automatic vec_t mk(bit ld, bit [2:0] op, bit [2:0] rd, bit [2:0] rs1, bit [2:0] rs2,
                               bit [31:0] imm, bit [31:0] exp);
      vec_t v;
      v.ld = ld; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
      return v;
   endfunction

   initial begin
      vec_t v;
      logic [31:0] held;

      // ld, op, rd, rs1, rs2, imm, expected rsp_data
      vecs.push_back(mk(1, 3'b000, 3'd1, 3'd0, 3'd0, 32'd5, 32'd5));
      vecs.push_back(mk(1, 3'b000, 3'd2, 3'd0, 3'd0, 32'd3, 32'd3));
      vecs.push_back(mk(0, 3'b101, 3'd3, 3'd1, 3'd2, 32'd0, 32'd8));
      vecs.push_back(mk(1, 3'b000, 3'd1, 3'd0, 3'd0, 32'd0, 32'd0));
      vecs.push_back(mk(0, 3'b100, 3'd4, 3'd1, 3'd0, 32'd0, 32'hFFFF_FFFF));
      vecs.push_back(mk(1, 3'b000, 3'd2, 3'd0, 3'd0, 32'd1, 32'd1));
      vecs.push_back(mk(0, 3'b110, 3'd5, 3'd1, 3'd2, 32'd0, 32'hFFFF_FFFF));
      vecs.push_back(mk(1, 3'b000, 3'd1, 3'd0, 3'd0, 32'h0F0F_0F0F, 32'h0F0F_0F0F));
      vecs.push_back(mk(0, 3'b010, 3'd1, 3'd1, 3'd1, 32'd0, 32'd0));
      vecs.push_back(mk(0, 3'b000, 3'd1, 3'd1, 3'd0, 32'd0, 32'hFFFF_FFFF));
      vecs.push_back(mk(1, 3'b000, 3'd1, 3'd0, 3'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5));
      vecs.push_back(mk(1, 3'b000, 3'd2, 3'd0, 3'd0, 32'h0000_FFFF, 32'h0000_FFFF));
      vecs.push_back(mk(0, 3'b000, 3'd3, 3'd1, 3'd2, 32'd0, 32'h5A5A_5A5A));
      vecs.push_back(mk(0, 3'b001, 3'd3, 3'd1, 3'd2, 32'd0, 32'h0000_A5A5));
      vecs.push_back(mk(0, 3'b010, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A5_5A5A));
      vecs.push_back(mk(0, 3'b011, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A5_FFFF));
      vecs.push_back(mk(0, 3'b100, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A5_A5A4));
      vecs.push_back(mk(0, 3'b101, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A6_A5A4));
      vecs.push_back(mk(0, 3'b110, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A4_A5A6));
      vecs.push_back(mk(0, 3'b111, 3'd3, 3'd1, 3'd2, 32'd0, 32'hA5A5_A5A6));
      // Result written back to r3 is read by the next command.
      vecs.push_back(mk(0, 3'b011, 3'd4, 3'd3, 3'd3, 32'd0, 32'hA5A5_A5A6));

      reset = 1'b1; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0; cmd_rd = '0;
      cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; rsp_ready = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset cmd_ready", 32'(cmd_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data", rsp_data, 32'd0);
      check("reset rsp_rd", 32'(rsp_rd), 32'd0);
      check("reset alu_a", alu_a, 32'd0);
      check("reset alu_b", alu_b, 32'd0);
      check("reset alu_f", 32'(alu_f), 32'd0);
      reset = 1'b0;
      #1;
      check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

      // rsp_ready with nothing pending does nothing
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("idle rsp_ready rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle rsp_ready cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_cmd(vecs[i], $sformatf("vec%0d", i));
      end

      // Load still samples operands and ignores the ALU result
      cmd_ld = 1'b1; cmd_op = 3'b101; cmd_rd = 3'd6; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
      cmd_imm = 32'h1234_5678; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("ld alu_a", alu_a, 32'hA5A5_A5A5);
      check("ld alu_b", alu_b, 32'h0000_FFFF);
      check("ld alu_f", 32'(alu_f), 32'd5);
      @(posedge clk); #1;
      check("ld rsp_data", rsp_data, 32'h1234_5678);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Backpressure: response held, extra command ignored
      v = mk(0, 3'b111, 3'd5, 3'd6, 3'd0, 32'd0, 32'h1234_5679);
      cmd_ld = v.ld; cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_ld = 1'b1; cmd_rd = 3'd7; cmd_imm = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      held = rsp_data;
      check("bp first rsp_data", rsp_data, 32'h1234_5679);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
         check($sformatf("bp%0d rsp_data", c), rsp_data, held);
         check($sformatf("bp%0d rsp_rd", c), 32'(rsp_rd), 32'd5);
         check($sformatf("bp%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp release cmd_ready", 32'(cmd_ready), 32'd1);
      // r7 must still be zero: the ignored load never landed
      run_cmd(mk(0, 3'b111, 3'd6, 3'd7, 3'd0, 32'd0, 32'd1), "r7 untouched");

      // Reset on the ISSUE edge suppresses the writeback
      run_cmd(mk(1, 3'b000, 3'd5, 3'd0, 3'd0, 32'd7, 32'd7), "ld r5");
      cmd_ld = 1'b1; cmd_rd = 3'd5; cmd_imm = 32'd9; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("issue-reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("issue-reset rsp_data", rsp_data, 32'd0);
      check("issue-reset cmd_ready", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("issue-reset cmd_ready after", 32'(cmd_ready), 32'd1);
      run_cmd(mk(0, 3'b111, 3'd6, 3'd5, 3'd0, 32'd0, 32'd1), "r5 cleared");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
